// File: rtl/c_tile_dispatcher.sv
// C-output dispatcher: hands each output writer the C tile addresses of its processor in raster order
// through one shared, round-robin granted address generator, then counts tile completions until done.
module c_tile_dispatcher #(
    parameter int N                   = 4,
    parameter int ROWS_PROCESSORS     = 2,
    parameter int COLS_PROCESSORS     = 2,
    parameter int NUM_PROCESSORS      = ROWS_PROCESSORS * COLS_PROCESSORS,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int C_ELEM_BYTES        = 4,
    parameter int LEN_BITS            = $clog2(MAX_MATRIX_LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0] cmd_c_addr,
    input  logic [LEN_BITS-1:0]            cmd_len,
    output logic [NUM_PROCESSORS-1:0]      c_address_valids,
    input  logic [NUM_PROCESSORS-1:0]      c_address_readys,
    output logic [MEMORY_ADDRESS_BITS-1:0] c_address_out,
    input  logic [NUM_PROCESSORS-1:0]      tile_done,
    output logic                           done,
    output logic                           err
);

    // state | meaning
    // IDLE  | waiting for a job
    // GRANT | pick the next ready writer that still owes passes
    // OFFER | address held on the bus until the granted writer takes it
    // WAIT  | all addresses issued, counting remaining tile completions
    // DONE  | job finished (or rejected, err=1); a new job may be accepted

    localparam int NP       = NUM_PROCESSORS;
    localparam int MAB      = MEMORY_ADDRESS_BITS;
    localparam int T_BITS   = $clog2(MAX_MATRIX_LENGTH / N + 1);
    localparam int CNT_BITS = 2 * T_BITS;
    localparam int IDX_BITS = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_MATRIX_LENGTH);
    localparam logic [LEN_BITS-1:0] ROW_MOD = LEN_BITS'(N * ROWS_PROCESSORS);
    localparam logic [LEN_BITS-1:0] COL_MOD = LEN_BITS'(N * COLS_PROCESSORS);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_OFFER, S_WAIT, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic [MAB-1:0]      r_base;
    logic [LEN_BITS-1:0] r_len;
    logic [T_BITS-1:0]   r_cg;
    logic [CNT_BITS-1:0] r_p;
    logic [CNT_BITS-1:0] r_total;
    logic [CNT_BITS-1:0] r_completed;
    logic [CNT_BITS-1:0] r_issued  [NP];
    logic [T_BITS-1:0]   r_pass_rg [NP];
    logic [T_BITS-1:0]   r_pass_cg [NP];
    logic [IDX_BITS-1:0] r_ptr;
    logic [IDX_BITS-1:0] r_win;
    logic [NP-1:0]       r_valids;
    logic [MAB-1:0]      r_addr;
    logic                r_err;

    logic                w_accept;
    logic                w_legal;
    logic [T_BITS-1:0]   w_t;
    logic [T_BITS-1:0]   w_rg;
    logic [T_BITS-1:0]   w_cg;
    logic [CNT_BITS-1:0] w_p;
    logic [CNT_BITS-1:0] w_total;
    logic [NP-1:0]       w_elig;
    logic                w_all_issued;
    logic                w_found;
    logic [IDX_BITS-1:0] w_pick;
    int                  w_idx;
    logic [MAB-1:0]      w_row;
    logic [MAB-1:0]      w_col;
    logic [MAB-1:0]      w_addr;
    logic                w_hs;
    logic                w_counting;
    logic [CNT_BITS-1:0] w_pop;
    logic [CNT_BITS-1:0] w_sum;
    logic [CNT_BITS-1:0] w_comp_next;

    assign w_legal = (cmd_len != '0) && (cmd_len <= MAX_LEN) &&
                     ((cmd_len % ROW_MOD) == '0) && ((cmd_len % COL_MOD) == '0);
    assign w_t     = T_BITS'(cmd_len / LEN_BITS'(N));
    assign w_rg    = w_t / T_BITS'(ROWS_PROCESSORS);
    assign w_cg    = w_t / T_BITS'(COLS_PROCESSORS);
    assign w_p     = CNT_BITS'(w_rg) * CNT_BITS'(w_cg);
    assign w_total = CNT_BITS'(w_t) * CNT_BITS'(w_t);

    assign w_accept = cmd_valid && cmd_ready;
    assign w_hs     = (r_state == S_OFFER) && ((r_valids & c_address_readys) != '0);

    always_comb begin
        w_elig       = '0;
        w_all_issued = 1'b1;
        for (int i = 0; i < NP; i++) begin
            w_elig[i] = c_address_readys[i] && (r_issued[i] < r_p);
            if (r_issued[i] != r_p) w_all_issued = 1'b0;
        end
    end

    // Scan from the pointer upwards with wrap; the lowest distance from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = NP - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NP) w_idx = w_idx - NP;
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_BITS'(w_idx);
            end
        end
    end

    // Per-writer rg/cg pass counters stand in for t/CG and t%CG, avoiding a runtime divider.
    always_comb begin
        w_row  = MAB'(r_pass_rg[w_pick]) * MAB'(ROWS_PROCESSORS) + MAB'(int'(w_pick) / COLS_PROCESSORS);
        w_col  = MAB'(r_pass_cg[w_pick]) * MAB'(COLS_PROCESSORS) + MAB'(int'(w_pick) % COLS_PROCESSORS);
        w_addr = r_base + (w_row * MAB'(N) * MAB'(r_len) + w_col * MAB'(N)) * MAB'(C_ELEM_BYTES);
    end

    assign w_counting  = (r_state == S_GRANT) || (r_state == S_OFFER) || (r_state == S_WAIT);
    assign w_pop       = CNT_BITS'($countones(tile_done));
    assign w_sum       = r_completed + w_pop;
    assign w_comp_next = (w_sum > r_total) ? r_total : w_sum;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = w_legal ? S_GRANT : S_DONE;
            end
            S_GRANT: begin
                if (w_all_issued) w_next = S_WAIT;
                else if (w_found) w_next = S_OFFER;
            end
            S_OFFER: begin
                if (w_hs) w_next = S_GRANT;
            end
            S_WAIT: begin
                if (r_completed == r_total) w_next = S_DONE;
            end
            S_DONE: begin
                cmd_ready = 1'b1;
                done      = 1'b1;
                if (cmd_valid) w_next = w_legal ? S_GRANT : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_cg        <= '0;
            r_p         <= '0;
            r_total     <= '0;
            r_completed <= '0;
            r_ptr       <= '0;
            r_win       <= '0;
            r_valids    <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                r_issued[i]  <= '0;
                r_pass_rg[i] <= '0;
                r_pass_cg[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_base      <= cmd_c_addr;
                r_len       <= cmd_len;
                r_cg        <= w_cg;
                r_p         <= w_p;
                r_total     <= w_total;
                r_completed <= '0;
                r_ptr       <= '0;
                r_err       <= !w_legal;
                for (int i = 0; i < NP; i++) begin
                    r_issued[i]  <= '0;
                    r_pass_rg[i] <= '0;
                    r_pass_cg[i] <= '0;
                end
            end
            if ((r_state == S_GRANT) && !w_all_issued && w_found) begin
                r_addr   <= w_addr;
                r_valids <= NP'(1) << w_pick;
                r_win    <= w_pick;
                r_ptr    <= (w_pick == IDX_BITS'(NP - 1)) ? '0 : w_pick + IDX_BITS'(1);
            end
            if (w_hs) begin
                r_valids        <= '0;
                r_issued[r_win] <= r_issued[r_win] + CNT_BITS'(1);
                if (r_pass_cg[r_win] == r_cg - T_BITS'(1)) begin
                    r_pass_cg[r_win] <= '0;
                    r_pass_rg[r_win] <= r_pass_rg[r_win] + T_BITS'(1);
                end else begin
                    r_pass_cg[r_win] <= r_pass_cg[r_win] + T_BITS'(1);
                end
            end
            if (w_counting) r_completed <= w_comp_next;
        end
    end

    assign c_address_valids = r_valids;
    assign c_address_out    = r_addr;
    assign err              = r_err;

endmodule
